// File: rtl/window_filter_ctrl_pkg.sv
// Shared types and constants for the 3x3 window filter sequencer.
//   state_t : sequencer state encoding
//   tag_t   : per-window side information carried alongside the adder
//   mean9   : divide-by-9 approximation of a 3x3 window sum
package win_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  // 57/512 = 0.1113, close enough to 1/9 that a full-scale sum still maps to 255.
  localparam int MEAN_MUL   = 57;
  localparam int MEAN_SHIFT = 9;

  typedef struct packed {
    logic       valid;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       border;
    logic [7:0] center;
  } tag_t;

  function automatic logic [7:0] mean9(input logic [11:0] sum);
    logic [17:0] prod;
    prod = 18'(sum) * 18'(MEAN_MUL);
    return prod[MEAN_SHIFT +: 8];
  endfunction

endpackage

// File: rtl/window_filter_ctrl_if.sv
// Window-in / pixel-out signal bundle of the window filter sequencer.
//   master : upstream window source and downstream pixel sink (drives in_*, sum_in)
//   slave  : the sequencer (drives out_*, frame_err, busy)
interface window_filter_ctrl_if;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_center;
  logic [11:0] sum_in;
  logic        out_valid;
  logic [7:0]  out_pix;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;
  logic        out_border;
  logic        frame_err;
  logic        busy;

  modport master (
    output in_valid, in_sof, in_center, sum_in,
    input  out_valid, out_pix, out_sof, out_eol, out_eof, out_border, frame_err, busy
  );

  modport slave (
    input  in_valid, in_sof, in_center, sum_in,
    output out_valid, out_pix, out_sof, out_eol, out_eof, out_border, frame_err, busy
  );
endinterface

// File: rtl/window_filter_ctrl_tag_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
//   clk   : clock
//   clr_n : synchronous clear, all stages to zero
//   d     : stage 0 input, loaded every cycle
//   q     : last stage output (DEPTH cycles after d)
module tag_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/window_filter_ctrl.sv
// Sequencer for the 3x3 window adder: tracks frame position, tags each
// accepted window, realigns the adder sum with its tag and emits the framed
// filtered pixel stream.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of window_filter_ctrl_if (windows in, pixels out)
//
// state  | meaning
// IDLE   | no frame open, waiting for an sof window
// ACTIVE | frame open, every valid window accepted
// FLUSH  | eof accepted, waiting for the adder pipeline to drain
module window_filter_ctrl
  import win_ctrl_pkg::*;
#(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int ADD_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  window_filter_ctrl_if.slave bus
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam int            DW     = $clog2(ADD_LAT + 2);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(ADD_LAT + 1);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DW-1:0] drain;
  logic          err_q;

  logic          accept;
  logic          bad;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          eol;
  logic          eof;
  logic          border;
  tag_t          tag_in;
  tag_t          tag_out;

  always_comb begin
    accept = 1'b0;
    bad    = 1'b0;
    unique case (state)
      ACTIVE: begin
        accept = bus.in_valid;
        bad    = bus.in_valid & bus.in_sof;
      end
      default: begin
        accept = bus.in_valid & bus.in_sof;
        bad    = bus.in_valid & ~bus.in_sof;
      end
    endcase
  end

  // An sof window always restarts at the origin, even mid-frame.
  assign px     = bus.in_sof ? '0 : x;
  assign py     = bus.in_sof ? '0 : y;
  assign eol    = (px == X_LAST);
  assign eof    = eol && (py == Y_LAST);
  assign border = (px == '0) || eol || (py == '0) || (py == Y_LAST);

  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.valid  = 1'b1;
      tag_in.sof    = bus.in_sof;
      tag_in.eol    = eol;
      tag_in.eof    = eof;
      tag_in.border = border;
      tag_in.center = bus.in_center;
    end
  end

  tag_delay #(
    .DEPTH(ADD_LAT),
    .WIDTH($bits(tag_t))
  ) u_tag_delay (
    .clk  (clk),
    .clr_n(rst_n),
    .d    (tag_in),
    .q    (tag_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      drain <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= bad;
      if (accept) begin
        if (eof) begin
          x     <= '0;
          y     <= '0;
          drain <= DRAIN_INIT;
          state <= FLUSH;
        end else if (eol) begin
          x     <= '0;
          y     <= py + 1'b1;
          state <= ACTIVE;
        end else begin
          x     <= px + 1'b1;
          y     <= py;
          state <= ACTIVE;
        end
      end else if (state == FLUSH) begin
        if (drain == '0) state <= IDLE;
        else             drain <= drain - 1'b1;
      end
    end
  end

  logic       ov_q, osof_q, oeol_q, oeof_q, obrd_q;
  logic [7:0] opix_q;

  // sum_in arrives exactly when the matching tag reaches the last stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_q   <= 1'b0;
      osof_q <= 1'b0;
      oeol_q <= 1'b0;
      oeof_q <= 1'b0;
      obrd_q <= 1'b0;
      opix_q <= '0;
    end else begin
      ov_q   <= tag_out.valid;
      osof_q <= tag_out.sof;
      oeol_q <= tag_out.eol;
      oeof_q <= tag_out.eof;
      obrd_q <= tag_out.border;
      if (tag_out.valid)
        opix_q <= tag_out.border ? tag_out.center : mean9(bus.sum_in);
    end
  end

  assign bus.out_valid  = ov_q;
  assign bus.out_pix    = opix_q;
  assign bus.out_sof    = osof_q;
  assign bus.out_eol    = oeol_q;
  assign bus.out_eof    = oeof_q;
  assign bus.out_border = obrd_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state != IDLE);

endmodule
